// File: rtl/vector_writeback_merge_if.sv
// Handshake bundle between the vector ALU, the writeback merge stage and the
// vector register file write port. The slave view belongs to the merge stage.
interface vector_writeback_merge_if;
    logic         valid_i;
    logic         ready_o;
    logic [511:0] result_i;
    logic [511:0] old_value_i;
    logic [15:0]  mask_i;
    logic [4:0]   dest_i;
    logic         wb_valid_o;
    logic         wb_ready_i;
    logic [511:0] wb_value_o;
    logic [15:0]  wb_mask_o;
    logic [4:0]   wb_dest_o;
    logic [15:0]  drop_count_o;

    modport master (
        output valid_i, result_i, old_value_i, mask_i, dest_i, wb_ready_i,
        input  ready_o, wb_valid_o, wb_value_o, wb_mask_o, wb_dest_o, drop_count_o
    );

    modport slave (
        input  valid_i, result_i, old_value_i, mask_i, dest_i, wb_ready_i,
        output ready_o, wb_valid_o, wb_value_o, wb_mask_o, wb_dest_o, drop_count_o
    );
endinterface

// File: rtl/vector_writeback_merge.sv
// Per-lane merge of the ALU result with the destination's old contents, followed
// by a two-entry (OUT + SKID) buffer so the register file can stall without a
// combinational ready path back into the ALU stage.
module vector_writeback_merge (
    input  logic                      clk,
    input  logic                      reset,
    vector_writeback_merge_if.slave   bus
);
    localparam int LANES  = 16;
    localparam int LANE_W = 32;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [LANES*LANE_W-1:0] value;
        logic [LANES-1:0]        mask;
        logic [4:0]              dest;
    } entry_t;

    state_t                  r_state;
    entry_t                  r_out;
    entry_t                  r_skid;
    logic                    r_ready;
    logic                    r_wb_valid;
    logic [15:0]             r_drop_count;

    logic [LANES*LANE_W-1:0] w_merged;
    entry_t                  w_entry;
    logic                    w_accept;
    logic                    w_store;
    logic                    w_drop;
    logic                    w_drain;

    always_comb begin
        // NOTE: default assignment first so every bit is written on every path and no latch is inferred.
        w_merged = bus.old_value_i;
        for (int i = 0; i < LANES; i++) begin
            if (bus.mask_i[i]) begin
                w_merged[i*LANE_W +: LANE_W] = bus.result_i[i*LANE_W +: LANE_W];
            end
        end
    end

    assign w_entry  = '{value: w_merged, mask: bus.mask_i, dest: bus.dest_i};
    assign w_accept = bus.valid_i & bus.ready_o;
    assign w_store  = w_accept & (|bus.mask_i);
    assign w_drop   = w_accept & ~(|bus.mask_i);
    assign w_drain  = r_wb_valid & bus.wb_ready_i;

    // Ready is a registered state flag; only reset reaches it combinationally.
    assign bus.ready_o      = ~reset & r_ready;
    assign bus.wb_valid_o   = r_wb_valid;
    assign bus.wb_value_o   = r_out.value;
    assign bus.wb_mask_o    = r_out.mask;
    assign bus.wb_dest_o    = r_out.dest;
    assign bus.drop_count_o = r_drop_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the entry registers are cleared as well, so a reset mid-stream discards OUT and SKID outright.
            r_state      <= ST_EMPTY;
            r_out        <= '0;
            r_skid       <= '0;
            r_ready      <= 1'b1;
            r_wb_valid   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            if (w_drop) begin
                r_drop_count <= r_drop_count + 16'd1;
            end

            case (r_state)
                ST_EMPTY: begin
                    if (w_store) begin
                        r_out      <= w_entry;
                        r_state    <= ST_BUSY;
                        r_wb_valid <= 1'b1;
                    end
                end

                ST_BUSY: begin
                    if (w_store && w_drain) begin
                        r_out <= w_entry;
                    end else if (w_store) begin
                        r_skid  <= w_entry;
                        r_state <= ST_FULL;
                        r_ready <= 1'b0;
                    end else if (w_drain) begin
                        r_state    <= ST_EMPTY;
                        r_wb_valid <= 1'b0;
                    end
                end

                ST_FULL: begin
                    // ready_o is low here, so the only event is the OUT drain.
                    if (w_drain) begin
                        r_out   <= r_skid;
                        r_state <= ST_BUSY;
                        r_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state    <= ST_EMPTY;
                    r_ready    <= 1'b1;
                    r_wb_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_writeback_merge.sv
// Directed bench for vector_writeback_merge: reset, single write, streaming,
// backpressure, zero-mask drop and counter wrap, reset while FULL.
module tb_vector_writeback_merge;
    logic clk;
    logic reset;
    int   n_vectors;
    int   n_miscompares;

    vector_writeback_merge_if bus ();

    vector_writeback_merge dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] rep(input logic [31:0] x);
        return {16{x}};
    endfunction

    task automatic drive(input logic v, input logic [511:0] res, input logic [511:0] old,
                         input logic [15:0] m, input logic [4:0] d);
        bus.valid_i     = v;
        bus.result_i    = res;
        bus.old_value_i = old;
        bus.mask_i      = m;
        bus.dest_i      = d;
    endtask

    initial begin
        logic [511:0] exp_v;
        int           wb_seen;

        n_vectors     = 0;
        n_miscompares = 0;
        reset         = 1'b1;
        bus.wb_ready_i = 1'b1;
        drive(1'b0, '0, '0, 16'h0, 5'd0);

        // Reset state
        tick();
        tick();
        check("rst_ready", bus.ready_o, 1'b0);
        check("rst_wb_valid", bus.wb_valid_o, 1'b0);
        check("rst_wb_value", bus.wb_value_o, '0);
        check("rst_drop", bus.drop_count_o, 16'h0);
        reset = 1'b0;
        #1;
        check("ready_after_rst", bus.ready_o, 1'b1);

        // Single write, lanes 0 and 15 take the result
        drive(1'b1, rep(32'hAAAAAAAA), rep(32'h55555555), 16'h8001, 5'd7);
        tick();
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        exp_v = {32'hAAAAAAAA, {14{32'h55555555}}, 32'hAAAAAAAA};
        check("single_valid", bus.wb_valid_o, 1'b1);
        check("single_value", bus.wb_value_o, exp_v);
        check("single_dest", bus.wb_dest_o, 5'd7);
        check("single_mask", bus.wb_mask_o, 16'h8001);
        tick();
        check("single_empty", bus.wb_valid_o, 1'b0);

        // Back-to-back stream of 8 full-mask items
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, rep(32'(i)), rep(32'hFFFFFFFF), 16'hFFFF, 5'(i));
            check("b2b_ready", bus.ready_o, 1'b1);
            tick();
            check("b2b_valid", bus.wb_valid_o, 1'b1);
            check("b2b_value", bus.wb_value_o, rep(32'(i)));
            check("b2b_dest", bus.wb_dest_o, 5'(i));
        end
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        tick();
        check("b2b_empty", bus.wb_valid_o, 1'b0);

        // Backpressure: item 2 lands in SKID, item 3 is held upstream
        bus.wb_ready_i = 1'b0;
        drive(1'b1, rep(32'h1), rep(32'hDEADBEEF), 16'hFFFF, 5'd1);
        check("bp_ready1", bus.ready_o, 1'b1);
        tick();
        drive(1'b1, rep(32'h2), rep(32'hDEADBEEF), 16'h00FF, 5'd2);
        check("bp_ready2", bus.ready_o, 1'b1);
        tick();
        drive(1'b1, rep(32'h3), rep(32'hCAFEF00D), 16'hFFFF, 5'd3);
        check("bp_ready_low", bus.ready_o, 1'b0);
        tick();
        check("bp_ready_held", bus.ready_o, 1'b0);
        check("bp_out_stable", bus.wb_value_o, rep(32'h1));
        check("bp_dest1", bus.wb_dest_o, 5'd1);
        bus.wb_ready_i = 1'b1;
        tick();
        exp_v = {{8{32'hDEADBEEF}}, {8{32'h00000002}}};
        check("bp_value2", bus.wb_value_o, exp_v);
        check("bp_dest2", bus.wb_dest_o, 5'd2);
        check("bp_mask2", bus.wb_mask_o, 16'h00FF);
        check("bp_ready_back", bus.ready_o, 1'b1);
        tick();
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        check("bp_value3", bus.wb_value_o, rep(32'h3));
        check("bp_dest3", bus.wb_dest_o, 5'd3);
        tick();
        check("bp_empty", bus.wb_valid_o, 1'b0);

        // Zero-mask item between two normal items
        check("zm_drop0", bus.drop_count_o, 16'h0);
        drive(1'b1, rep(32'h11111111), rep(32'h22222222), 16'h000F, 5'd3);
        tick();
        check("zm_a_value", bus.wb_value_o, {{12{32'h22222222}}, {4{32'h11111111}}});
        check("zm_a_dest", bus.wb_dest_o, 5'd3);
        drive(1'b1, rep(32'h99999999), rep(32'h88888888), 16'h0000, 5'd9);
        tick();
        check("zm_no_fwd", bus.wb_valid_o, 1'b0);
        check("zm_drop1", bus.drop_count_o, 16'h1);
        drive(1'b1, rep(32'h11111111), rep(32'h22222222), 16'hF000, 5'd4);
        tick();
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        check("zm_b_value", bus.wb_value_o, {{4{32'h11111111}}, {12{32'h22222222}}});
        check("zm_b_dest", bus.wb_dest_o, 5'd4);
        check("zm_b_mask", bus.wb_mask_o, 16'hF000);
        tick();
        check("zm_empty", bus.wb_valid_o, 1'b0);

        // Counter wrap: 65535 more zero-mask accepts take the count from 1 back to 0
        wb_seen = 0;
        drive(1'b1, rep(32'h12345678), '0, 16'h0000, 5'd0);
        for (int k = 0; k < 65535; k++) begin
            tick();
            if (bus.wb_valid_o) wb_seen++;
            if (k == 65533) check("wrap_ffff", bus.drop_count_o, 16'hFFFF);
        end
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        check("wrap_zero", bus.drop_count_o, 16'h0);
        check("wrap_no_wb", wb_seen, 0);

        // Fill to FULL, then reset
        bus.wb_ready_i = 1'b0;
        drive(1'b1, rep(32'hA1A1A1A1), '0, 16'hFFFF, 5'd10);
        tick();
        drive(1'b1, rep(32'hB2B2B2B2), '0, 16'hFFFF, 5'd11);
        tick();
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        check("full_ready", bus.ready_o, 1'b0);
        check("full_valid", bus.wb_valid_o, 1'b1);
        drive(1'b1, rep(32'h1), '0, 16'h0000, 5'd0);
        tick();
        check("pre_rst_drop", bus.drop_count_o, 16'h0);
        drive(1'b1, rep(32'h1), '0, 16'h0000, 5'd0);
        reset = 1'b1;
        #1;
        check("rst_full_ready_in", bus.ready_o, 1'b0);
        tick();
        drive(1'b0, '0, '0, 16'h0, 5'd0);
        check("rstf_valid", bus.wb_valid_o, 1'b0);
        check("rstf_value", bus.wb_value_o, '0);
        check("rstf_mask", bus.wb_mask_o, 16'h0);
        check("rstf_dest", bus.wb_dest_o, 5'd0);
        check("rstf_drop", bus.drop_count_o, 16'h0);
        check("rstf_ready", bus.ready_o, 1'b0);
        reset = 1'b0;
        #1;
        check("rstf_ready_after", bus.ready_o, 1'b1);
        bus.wb_ready_i = 1'b1;
        wb_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.wb_valid_o) wb_seen++;
        end
        check("rstf_no_stale", wb_seen, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end
endmodule

// File: doc/vector_writeback_merge.md
# vector_writeback_merge

Pipeline stage directly downstream of the 16-lane single-cycle vector ALU. Takes the 512-bit lane-parallel ALU result, merges it per lane with the destination register's old contents under a 16-bit lane mask, and presents the merged vector to the vector register file write port. A valid/ready handshake with a two-entry skid buffer lets the register file stall without a combinational ready path back into the ALU stage.

## Interface
- LANES, 16, number of 32-bit lanes; fixed at 16 (512-bit vectors)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- valid_i  input  1  upstream presents a result this cycle
- ready_o  output  1  stage accepts a result this cycle
- result_i  input  512  ALU result; lane i = bits [32i+31:32i] (lane 0 = [31:0], lane 15 = [511:480])
- old_value_i  input  512  current contents of destination register, same lane order
- mask_i  input  16  lane write enable; bit i selects lane i
- dest_i  input  5  destination vector register index
- wb_valid_o  output  1  merged write pending
- wb_ready_i  input  1  register file accepts the write this cycle
- wb_value_o  output  512  merged vector
- wb_mask_o  output  16  mask of the write (passed through)
- wb_dest_o  output  5  destination register index
- drop_count_o  output  16  number of accepted results discarded for all-zero mask

## Operation
- accept = valid_i & ready_o; drain = wb_valid_o & wb_ready_i.
- Merge (combinational, before capture): lane i = mask_i[i] ? result_i lane i : old_value_i lane i. Captured entry = {merged, mask_i, dest_i}.
- Zero-mask rule: an accepted item with mask_i == 0 is consumed (handshake completes) but never stored or forwarded; drop_count_o increments by 1, wraps 0xFFFF -> 0x0000.
- Storage: output register (OUT) drives wb_*_o; skid register (SKID) holds one extra entry.
- States: EMPTY (OUT, SKID invalid), BUSY (OUT valid), FULL (OUT and SKID valid). "store" = accept with mask_i != 0.
- EMPTY: store -> BUSY, entry into OUT; otherwise stay.
- BUSY: store & drain -> BUSY, new entry into OUT; store & !drain -> FULL, entry into SKID; !store & drain -> EMPTY; else stay.
- FULL: drain -> BUSY, SKID moves into OUT; else stay. No accept possible (ready_o = 0).
- ready_o = !reset & (state != FULL); depends only on state, never on valid_i or wb_ready_i.
- wb_valid_o = (state != EMPTY). wb_*_o hold stable while wb_valid_o & !wb_ready_i.
- Order preserved: entries leave in acceptance order.
- Reset: state EMPTY; wb_valid_o = 0; wb_value_o = 0; wb_mask_o = 0; wb_dest_o = 0; drop_count_o = 0; SKID contents = 0; ready_o = 0 while reset is high, 1 on the first cycle after. Reset mid-operation discards OUT and SKID without draining.

## Timing
- Latency: store in cycle N -> wb_valid_o with that entry in cycle N+1 (EMPTY, or BUSY with drain).
- Throughput: 1 entry/cycle while wb_ready_i held high.
- One stall cycle from the register file fills SKID; ready_o drops the following cycle and stays low until OUT drains.
- old_value_i is sampled in the acceptance cycle only; later changes to the destination register do not affect the stored entry.
- drop_count_o updates the cycle after the zero-mask accept.

## Test plan
- Single write: mask_i=0x8001, result lanes=0xAAAAAAAA, old lanes=0x55555555, dest_i=7, wb_ready_i=1 -> next cycle wb_valid_o=1, lanes 0 and 15 = 0xAAAAAAAA, lanes 1-14 = 0x55555555, wb_dest_o=7, wb_mask_o=0x8001; EMPTY following cycle.
- Back-to-back: 8 consecutive valid_i items, mask 0xFFFF, result lane values = item index, wb_ready_i=1 -> 8 consecutive wb_valid_o cycles in order, ready_o never drops.
- Backpressure: wb_ready_i=0 while 3 items offered -> items 1 and 2 accepted, ready_o=0 from the cycle after item 2, item 3 held upstream; raise wb_ready_i -> outputs 1, 2, 3 in order, no loss or duplication.
- Zero mask: item with mask_i=0x0000 between two normal items -> only the two normal items appear on wb_*; drop_count_o goes 0 -> 1.
- Counter wrap: 65536 zero-mask accepts -> drop_count_o returns to 0x0000, wb_valid_o never asserted.
- Reset in FULL: fill to FULL with wb_ready_i=0, assert reset for 1 cycle -> wb_valid_o=0, all wb_*_o=0, drop_count_o=0, ready_o=0 during reset and 1 the next cycle; no stale entry emitted afterwards.
